// File: rtl/hero_run_anim_ctrl_if.sv
// Sprite memory bus between the hero animation controller and the ROM/palette.
// Latency: none (signal bundle only).
// Backpressure: none; the ROM answers one address per clock and the palette is a pure lookup.
//
// Signals:
//   rom_addr   controller -> ROM      sprite ROM address (registered in the controller)
//   rom_index  ROM -> controller      palette index, valid one clock after rom_addr
//   pal_index  controller -> palette  copy of rom_index
//   pal_r/g/b  palette -> controller  colour for pal_index, combinational
interface hero_run_anim_ctrl_if #(
    parameter int ADDR_W = 13
);
    logic [ADDR_W-1:0] rom_addr;
    logic [2:0]        rom_index;
    logic [2:0]        pal_index;
    logic [3:0]        pal_r;
    logic [3:0]        pal_g;
    logic [3:0]        pal_b;

    // Controller side
    modport master (
        output rom_addr,
        output pal_index,
        input  rom_index,
        input  pal_r,
        input  pal_g,
        input  pal_b
    );

    // ROM + palette side
    modport slave (
        input  rom_addr,
        input  pal_index,
        output rom_index,
        output pal_r,
        output pal_g,
        output pal_b
    );
endinterface

// File: rtl/hero_run_anim_ctrl.sv
// Hero running-animation sequencer: steps a 4-frame run cycle on video-frame ticks and maps draw coords to sprite ROM -> palette -> RGB.
// Latency: 3 Clk from draw_x/draw_y to red/green/blue and pix_valid, one pixel per clock.
// Backpressure: none; the pipeline advances every clock and cannot stall.
//
// Ports:
//   Clk, Reset_n          pixel clock, asynchronous active-low reset
//   frame_start           one-clock pulse per video frame; the only time the animation state moves
//   running               hero is running, sampled on frame_start
//   facing_left           mirror the sprite horizontally, sampled with draw_x
//   hero_x, hero_y        sprite top-left corner on screen
//   draw_x, draw_y        current VGA pixel
//   mem                   sprite ROM / palette bus (master side)
//   frame_sel             current animation frame
//   pix_valid             opaque hero pixel at the 3-clock-delayed coordinate
//   red, green, blue      colour for the delayed coordinate, zero when pix_valid is low
module hero_run_anim_ctrl #(
    parameter int SPRITE_W        = 32,
    parameter int SPRITE_H        = 48,
    parameter int FRAMES          = 4,
    parameter int TICKS_PER_FRAME = 6,
    parameter int ADDR_W          = 13
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic                        frame_start,
    input  logic                        running,
    input  logic                        facing_left,
    input  logic [9:0]                  hero_x,
    input  logic [9:0]                  hero_y,
    input  logic [9:0]                  draw_x,
    input  logic [9:0]                  draw_y,
    hero_run_anim_ctrl_if.master        mem,
    output logic [1:0]                  frame_sel,
    output logic                        pix_valid,
    output logic [3:0]                  red,
    output logic [3:0]                  green,
    output logic [3:0]                  blue
);

    localparam int TICK_W    = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
    localparam int FRAME_PIX = SPRITE_W * SPRITE_H;

    localparam logic [TICK_W-1:0] LAST_TICK  = TICK_W'(TICKS_PER_FRAME - 1);
    localparam logic [TICK_W-1:0] FIRST_TICK = TICK_W'(1);
    localparam logic [1:0]        LAST_FRAME = 2'(FRAMES - 1);

    localparam logic [9:0] SPR_W10   = 10'(SPRITE_W);
    localparam logic [9:0] SPR_H10   = 10'(SPRITE_H);
    localparam logic [9:0] SPR_WM1   = 10'(SPRITE_W - 1);

    typedef enum logic {
        STAND = 1'b0,
        RUN   = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Animation FSM
    // ------------------------------------------------------------------
    state_t              state_q, state_nxt;
    logic [TICK_W-1:0]   tick_q,  tick_nxt;
    logic [1:0]          frame_q, frame_nxt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= STAND;
            tick_q  <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_nxt;
            tick_q  <= tick_nxt;
            frame_q <= frame_nxt;
        end
    end

    // Everything holds between frame_start pulses, so frame_sel can only
    // change during vblank and a visible frame never mixes two sprites.
    always_comb begin
        state_nxt = state_q;
        tick_nxt  = tick_q;
        frame_nxt = frame_q;
        if (frame_start) begin
            case (state_q)
                STAND: begin
                    frame_nxt = '0;
                    tick_nxt  = '0;
                    if (running) begin
                        // The entry pulse already counts as the first tick.
                        state_nxt = RUN;
                        tick_nxt  = FIRST_TICK;
                    end
                end
                RUN: begin
                    if (!running) begin
                        state_nxt = STAND;
                        frame_nxt = '0;
                        tick_nxt  = '0;
                    end else if (tick_q == LAST_TICK) begin
                        tick_nxt  = '0;
                        frame_nxt = (frame_q == LAST_FRAME) ? 2'd0 : frame_q + 2'd1;
                    end else begin
                        tick_nxt  = tick_q + TICK_W'(1);
                    end
                end
                default: begin
                    state_nxt = STAND;
                    frame_nxt = '0;
                    tick_nxt  = '0;
                end
            endcase
        end
    end

    always_comb begin
        frame_sel = frame_q;
    end

    // ------------------------------------------------------------------
    // Stage 0: coordinate to sprite-local position
    // ------------------------------------------------------------------
    // Unsigned wrap makes pixels left of / above the sprite look huge, so a
    // single less-than per axis covers both sides of the box.
    logic [9:0]        dx, dy, col;
    logic              in_box;
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        dx     = draw_x - hero_x;
        dy     = draw_y - hero_y;
        in_box = (dx < SPR_W10) && (dy < SPR_H10);
        col    = facing_left ? (SPR_WM1 - dx) : dx;
        // Address is formed even out of the box; v1 masks the result later.
        addr_d = ADDR_W'(frame_q) * ADDR_W'(FRAME_PIX)
               + ADDR_W'(dy) * ADDR_W'(SPRITE_W)
               + ADDR_W'(col);
    end

    // ------------------------------------------------------------------
    // Stages 1..3: ROM address, ROM data, registered colour
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] rom_addr_q;
    logic              v1_q, v2_q;
    logic              pix_valid_q;
    logic [11:0]       rgb_q;
    logic              pix_valid_d;
    logic [11:0]       rgb_d;

    // Palette index 0 is the transparent key.
    always_comb begin
        pix_valid_d = v2_q && (mem.rom_index != 3'd0);
        rgb_d       = pix_valid_d ? {mem.pal_r, mem.pal_g, mem.pal_b} : 12'h000;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr_q  <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            pix_valid_q <= 1'b0;
            rgb_q       <= 12'h000;
        end else begin
            rom_addr_q  <= addr_d;
            v1_q        <= in_box;
            v2_q        <= v1_q;          // lines up with rom_index
            pix_valid_q <= pix_valid_d;
            rgb_q       <= rgb_d;
        end
    end

    assign mem.rom_addr  = rom_addr_q;
    assign mem.pal_index = mem.rom_index;

    assign pix_valid = pix_valid_q;
    assign red       = rgb_q[11:8];
    assign green     = rgb_q[7:4];
    assign blue      = rgb_q[3:0];

endmodule

// File: tb/tb_hero_run_anim_ctrl.sv
module tb_hero_run_anim_ctrl;

    logic       Clk;
    logic       Reset_n;
    logic       frame_start;
    logic       running;
    logic       facing_left;
    logic [9:0] hero_x, hero_y, draw_x, draw_y;
    logic [1:0] frame_sel;
    logic       pix_valid;
    logic [3:0] red, green, blue;

    logic [2:0]  rom_fill;
    logic [11:0] pal_rgb;

    int vectors     = 0;
    int miscompares = 0;

    hero_run_anim_ctrl_if #(.ADDR_W(13)) mem_if ();

    hero_run_anim_ctrl dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .running     (running),
        .facing_left (facing_left),
        .hero_x      (hero_x),
        .hero_y      (hero_y),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .mem         (mem_if),
        .frame_sel   (frame_sel),
        .pix_valid   (pix_valid),
        .red         (red),
        .green       (green),
        .blue        (blue)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Synchronous ROM: data appears one clock after the address.
    always @(posedge Clk) mem_if.rom_index <= rom_fill;

    // Combinational palette
    always_comb begin
        pal_rgb = 12'h5A5;
        case (mem_if.pal_index)
            3'd1:    pal_rgb = 12'h123;
            3'd4:    pal_rgb = 12'hE30;
            default: pal_rgb = 12'h5A5;
        endcase
    end
    assign mem_if.pal_r = pal_rgb[11:8];
    assign mem_if.pal_g = pal_rgb[7:4];
    assign mem_if.pal_b = pal_rgb[3:0];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            frame_start = 1'b1;
            step(1);
            frame_start = 1'b0;
            step(1);
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset_n     = 1'b0;
        frame_start = 1'b0;
        running     = 1'b0;
        facing_left = 1'b0;
        hero_x      = 10'd100;
        hero_y      = 10'd200;
        draw_x      = 10'd0;
        draw_y      = 10'd0;
        rom_fill    = 3'd0;
        step(3);
        chk("rst_frame",  16'(frame_sel), 16'h0);
        chk("rst_addr",   16'(mem_if.rom_addr), 16'h0);
        chk("rst_pix",    16'(pix_valid), 16'h0);
        chk("rst_rgb",    16'({red, green, blue}), 16'h000);
        Reset_n = 1'b1;
        step(2);

        // Run cycle: first advance on the 6th pulse, wrap after 24
        running = 1'b1;
        pulses(5);
        chk("run_5",   16'(frame_sel), 16'd0);
        pulses(1);
        chk("run_6",   16'(frame_sel), 16'd1);
        pulses(12);
        chk("run_18",  16'(frame_sel), 16'd3);
        pulses(6);
        chk("wrap_24", 16'(frame_sel), 16'd0);

        // Back to STAND, then re-enter RUN on a single pulse (tick starts at 1)
        running = 1'b0;
        pulses(1);
        chk("stop",         16'(frame_sel), 16'd0);
        running = 1'b1;
        pulses(5);
        chk("reenter_5",    16'(frame_sel), 16'd0);
        pulses(1);
        chk("reenter_6",    16'(frame_sel), 16'd1);
        pulses(6);
        chk("frame2",       16'(frame_sel), 16'd2);

        // Address mapping at frame 2, top-left corner, both facings
        draw_x = 10'd100; draw_y = 10'd200; facing_left = 1'b0;
        step(1);
        chk("addr_right",   16'(mem_if.rom_addr), 16'd3072);
        facing_left = 1'b1;
        step(1);
        chk("addr_left",    16'(mem_if.rom_addr), 16'd3103);

        // Bottom-right corner, opaque index 4 -> E30
        facing_left = 1'b0;
        draw_x = 10'd131; draw_y = 10'd247; rom_fill = 3'd4;
        step(1);
        chk("addr_corner",  16'(mem_if.rom_addr), 16'd4607);
        step(2);
        chk("corner_pix",   16'(pix_valid), 16'h1);
        chk("corner_rgb",   16'({red, green, blue}), 16'hE30);

        // Outside the box: ROM data is opaque but must be masked
        draw_x = 10'd99;
        step(3);
        chk("left_pix",     16'(pix_valid), 16'h0);
        chk("left_rgb",     16'({red, green, blue}), 16'h000);
        draw_x = 10'd132;
        step(3);
        chk("right_pix",    16'(pix_valid), 16'h0);
        chk("right_rgb",    16'({red, green, blue}), 16'h000);
        draw_x = 10'd131; draw_y = 10'd248;
        step(3);
        chk("below_pix",    16'(pix_valid), 16'h0);

        // Back-to-back pixels: in-box then out-of-box on consecutive clocks
        draw_x = 10'd100; draw_y = 10'd200; rom_fill = 3'd1;
        step(1);
        draw_x = 10'd99;
        step(2);
        chk("pipe_a_pix",   16'(pix_valid), 16'h1);
        chk("pipe_a_rgb",   16'({red, green, blue}), 16'h123);
        step(1);
        chk("pipe_b_pix",   16'(pix_valid), 16'h0);
        chk("pipe_b_rgb",   16'({red, green, blue}), 16'h000);

        // Transparent key
        draw_x = 10'd100; rom_fill = 3'd0;
        step(3);
        chk("transp_pix",   16'(pix_valid), 16'h0);
        chk("transp_rgb",   16'({red, green, blue}), 16'h000);

        // running dropped mid-frame: frame holds until the next pulse
        pulses(6);
        chk("frame3",       16'(frame_sel), 16'd3);
        running = 1'b0;
        step(3);
        chk("hold_mid",     16'(frame_sel), 16'd3);
        running = 1'b1;
        step(1);
        running = 1'b0;
        step(1);
        chk("hold_toggle",  16'(frame_sel), 16'd3);
        pulses(1);
        chk("drop_pulse",   16'(frame_sel), 16'd0);

        // Reach frame 3 again and reset asynchronously with an opaque pixel in flight
        running = 1'b1;
        pulses(18);
        chk("frame3_again", 16'(frame_sel), 16'd3);
        draw_x = 10'd100; draw_y = 10'd200; rom_fill = 3'd4;
        step(3);
        chk("pre_rst_addr", 16'(mem_if.rom_addr), 16'd4608);
        chk("pre_rst_pix",  16'(pix_valid), 16'h1);
        chk("pre_rst_rgb",  16'({red, green, blue}), 16'hE30);
        #1 Reset_n = 1'b0;
        #1;
        chk("async_frame",  16'(frame_sel), 16'd0);
        chk("async_addr",   16'(mem_if.rom_addr), 16'd0);
        chk("async_pix",    16'(pix_valid), 16'h0);
        chk("async_rgb",    16'({red, green, blue}), 16'h000);
        step(2);
        Reset_n = 1'b1;

        // First valid output lands 3 clocks after the first post-reset sample
        step(2);
        chk("post_rst_p2",  16'(pix_valid), 16'h0);
        step(1);
        chk("post_rst_p3",  16'(pix_valid), 16'h1);
        chk("post_rst_rgb", 16'({red, green, blue}), 16'hE30);
        chk("post_rst_frm", 16'(frame_sel), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
